// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// Buffer entries pair a fetched word with its byte address.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } fetch_state_t;

    localparam logic [15:0] HALT_INSTR = 16'hEFFF;
    localparam logic [7:0]  PC_STEP    = 8'd2;

    typedef struct packed {
        logic [15:0] instr;
        logic [7:0]  pc;
    } ibuf_entry_t;

    function automatic logic [7:0] align_addr(
        input logic [7:0] a
    );
        return {a[7:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_ibuf.sv
// Two-entry fetch queue; slot0 is always the head so decode
// sees registered outputs only.
module fetch_ibuf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  ibuf_entry_t din,
    output logic        full,
    output logic        empty,
    output ibuf_entry_t head
);

    ibuf_entry_t slot0;
    ibuf_entry_t slot1;
    logic [1:0]  count;
    logic        do_pop;
    logic        do_push;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = slot0;

    // Flush only clears occupancy; stale data stays visible but invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            unique case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= din;
                    else               slot1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= din;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, fills the fetch queue from a
// combinational instruction memory, handles redirects and halt.
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  start_addr,
    output logic [7:0]  im_addr,
    input  logic [15:0] im_instr,
    input  logic        br_valid,
    input  logic [7:0]  br_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [15:0] if_instr,
    output logic [7:0]  if_pc,
    output logic        halted
);

    fetch_state_t state;
    fetch_state_t state_nx;
    logic [7:0]   pc;
    logic [7:0]   pc_nx;

    logic        redirect;
    logic        restart;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    ibuf_entry_t din;
    ibuf_entry_t head;

    // Redirect outranks start, push and halt detection.
    assign redirect = br_valid && (state != IDLE);
    assign restart  = start && (state != RUN) && !redirect;
    assign pop      = if_valid && if_ready;
    assign push     = (state == RUN) && !redirect
                    && (!full || pop);

    assign din.instr = im_instr;
    assign din.pc    = pc;

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        unique case (1'b1)
            redirect: begin
                state_nx = RUN;
                pc_nx    = align_addr(br_target);
            end
            restart: begin
                state_nx = RUN;
                pc_nx    = align_addr(start_addr);
            end
            push: begin
                if (im_instr == HALT_INSTR) state_nx = HALT;
                else                        pc_nx = pc + PC_STEP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= 8'h00;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
        end
    end

    fetch_ibuf u_ibuf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (din),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign im_addr  = pc;
    assign if_valid = !empty;
    assign if_instr = head.instr;
    assign if_pc    = head.pc;
    assign halted   = (state == HALT) && empty;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand sequences,
// then random traffic against a queue-based reference model.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  start_addr;
    logic [7:0]  im_addr;
    logic [15:0] im_instr;
    logic        br_valid;
    logic [7:0]  br_target;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [7:0]  if_pc;
    logic        halted;

    logic [15:0] mem [128];

    int n_tests;
    int n_fail;

    fetch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .im_addr    (im_addr),
        .im_instr   (im_instr),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .halted     (halted)
    );

    assign im_instr = mem[im_addr[7:1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [7:0]  sa;
        logic        br;
        logic [7:0]  bt;
        logic        rdy;
        logic        ev;
        logic [15:0] ei;
        logic [7:0]  ep;
        logic [7:0]  ea;
        logic        eh;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(
        input logic st, input logic [7:0] sa,
        input logic br, input logic [7:0] bt,
        input logic rdy, input logic ev,
        input logic [15:0] ei, input logic [7:0] ep,
        input logic [7:0] ea, input logic eh
    );
        vec_t r;
        r.st = st; r.sa = sa; r.br = br; r.bt = bt;
        r.rdy = rdy; r.ev = ev; r.ei = ei; r.ep = ep;
        r.ea = ea; r.eh = eh;
        return r;
    endfunction

    task automatic chk(
        input string name,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h",
                     name, got, exp);
        end
    endtask

    function automatic logic [41:0] obs();
        return {if_valid,
                if_valid ? if_instr : 16'h0,
                if_valid ? if_pc : 8'h0,
                im_addr, halted, 8'h00};
    endfunction

    function automatic logic [41:0] want(
        input logic ev, input logic [15:0] ei,
        input logic [7:0] ep, input logic [7:0] ea,
        input logic eh
    );
        return {ev, ev ? ei : 16'h0, ev ? ep : 8'h0,
                ea, eh, 8'h00};
    endfunction

    task automatic step(
        input logic st, input logic [7:0] sa,
        input logic br, input logic [7:0] bt,
        input logic rdy
    );
        @(negedge clk);
        start      = st;
        start_addr = sa;
        br_valid   = br;
        br_target  = bt;
        if_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    int          m_mode;  // 0 idle, 1 fetching, 2 halted
    logic [7:0]  m_pc;
    logic [23:0] m_q[$];

    task automatic model_step(
        input logic st, input logic [7:0] sa,
        input logic br, input logic [7:0] bt,
        input logic rdy
    );
        logic [15:0] w;
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        if (br && m_mode != 0) begin
            m_q.delete();
            m_pc   = bt & 8'hFE;
            m_mode = 1;
        end else if (st && m_mode != 1) begin
            m_pc   = sa & 8'hFE;
            m_mode = 1;
        end else if (m_mode == 1 && m_q.size() < 2) begin
            w = mem[m_pc[7:1]];
            m_q.push_back({w, m_pc});
            if (w == 16'hEFFF) m_mode = 2;
            else               m_pc = m_pc + 8'd2;
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = 8'h00;
        br_valid   = 1'b0;
        br_target  = 8'h00;
        if_ready   = 1'b0;

        for (int i = 0; i < 128; i++)
            mem[i] = {8'h10, 8'(i * 2)};
        mem[8'h00 >> 1] = 16'hF120;
        mem[8'h02 >> 1] = 16'hF121;
        mem[8'h04 >> 1] = 16'h93FF;
        mem[8'h30 >> 1] = 16'hFCC0;
        mem[8'h34 >> 1] = 16'hFCD0;
        mem[8'h36 >> 1] = 16'hEFFF;

        repeat (2) @(posedge clk);
        #1;
        chk("reset outs",
            {if_valid, if_instr, if_pc, im_addr, halted},
            {1'b0, 16'h0000, 8'h00, 8'h00, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        // start, sustained flow
        vt.push_back(v(1, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 1, 16'hF120, 8'h00, 8'h02, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 1, 16'hF121, 8'h02, 8'h04, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 1, 16'h93FF, 8'h04, 8'h06, 0));
        // redirect to 00 then backpressure
        vt.push_back(v(0, 8'h00, 1, 8'h00, 1, 0, 0, 0, 8'h00, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 0, 1, 16'hF120, 8'h00, 8'h02, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 0, 1, 16'hF120, 8'h00, 8'h04, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 0, 1, 16'hF120, 8'h00, 8'h04, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 0, 1, 16'hF120, 8'h00, 8'h04, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 0, 1, 16'hF120, 8'h00, 8'h04, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 1, 16'hF121, 8'h02, 8'h06, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 1, 16'h93FF, 8'h04, 8'h08, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 1, 16'h1006, 8'h06, 8'h0A, 0));
        // redirect to odd target while popping
        vt.push_back(v(0, 8'h00, 1, 8'h31, 1, 0, 0, 0, 8'h30, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 1, 16'hFCC0, 8'h30, 8'h32, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 1, 16'h1032, 8'h32, 8'h34, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 1, 16'hFCD0, 8'h34, 8'h36, 0));
        // halt word delivered, PC parks, halted after drain
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 1, 16'hEFFF, 8'h36, 8'h36, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h36, 1));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h36, 1));
        vt.push_back(v(1, 8'h00, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 1, 16'hF120, 8'h00, 8'h02, 0));
        // wrap around FE -> 00
        vt.push_back(v(0, 8'h00, 1, 8'hFC, 1, 0, 0, 0, 8'hFC, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 0, 1, 16'h10FC, 8'hFC, 8'hFE, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 0, 1, 16'h10FC, 8'hFC, 8'h00, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 1, 16'h10FE, 8'hFE, 8'h02, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 1, 16'hF120, 8'h00, 8'h04, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 1, 16'hF121, 8'h02, 8'h06, 0));
        // start while running is ignored
        vt.push_back(v(1, 8'h40, 0, 8'h00, 1, 1, 16'h93FF, 8'h04, 8'h08, 0));
        // halt with word still queued, then start+br together
        vt.push_back(v(0, 8'h00, 1, 8'h34, 1, 0, 0, 0, 8'h34, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 1, 16'hFCD0, 8'h34, 8'h36, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 1, 16'hEFFF, 8'h36, 8'h36, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 0, 1, 16'hEFFF, 8'h36, 8'h36, 0));
        vt.push_back(v(1, 8'h00, 1, 8'h31, 0, 0, 0, 0, 8'h30, 0));
        vt.push_back(v(0, 8'h00, 0, 8'h00, 1, 1, 16'hFCC0, 8'h30, 8'h32, 0));

        foreach (vt[i]) begin
            step(vt[i].st, vt[i].sa, vt[i].br,
                 vt[i].bt, vt[i].rdy);
            chk($sformatf("vec%0d", i), 64'(obs()),
                64'(want(vt[i].ev, vt[i].ei, vt[i].ep,
                         vt[i].ea, vt[i].eh)));
        end

        // async reset with two words queued
        step(0, 8'h00, 0, 8'h00, 0);
        chk("pre-reset full", 64'(obs()),
            64'(want(1, 16'hFCC0, 8'h30, 8'h34, 0)));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset",
            {if_valid, if_instr, if_pc, im_addr, halted},
            {1'b0, 16'h0000, 8'h00, 8'h00, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 8'h00, 1, 8'h40, 1);
        chk("idle ignores br", 64'(obs()),
            64'(want(0, 0, 0, 8'h00, 0)));
        step(0, 8'h00, 0, 8'h00, 1);
        chk("idle holds", 64'(obs()),
            64'(want(0, 0, 0, 8'h00, 0)));
        step(1, 8'h03, 0, 8'h00, 1);
        chk("restart odd", 64'(obs()),
            64'(want(0, 0, 0, 8'h02, 0)));
        step(0, 8'h00, 0, 8'h00, 1);
        chk("restart word", 64'(obs()),
            64'(want(1, 16'hF121, 8'h02, 8'h04, 0)));

        // random traffic against the reference model
        for (int i = 0; i < 128; i++) begin
            mem[i] = 16'($urandom);
            if (mem[i] == 16'hEFFF) mem[i] = 16'h0000;
            if ($urandom_range(0, 11) == 0) mem[i] = 16'hEFFF;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        m_mode = 0;
        m_pc   = 8'h00;
        m_q.delete();

        for (int c = 0; c < 3000; c++) begin
            logic        r_st;
            logic [7:0]  r_sa;
            logic        r_br;
            logic [7:0]  r_bt;
            logic        r_rdy;
            logic [23:0] hd;
            r_st  = ($urandom_range(0, 9) == 0);
            r_sa  = 8'($urandom);
            r_br  = ($urandom_range(0, 15) == 0);
            r_bt  = 8'($urandom);
            r_rdy = ($urandom_range(0, 3) != 0);
            model_step(r_st, r_sa, r_br, r_bt, r_rdy);
            step(r_st, r_sa, r_br, r_bt, r_rdy);
            hd = (m_q.size() > 0) ? m_q[0] : 24'h0;
            chk($sformatf("rand cyc%0d", c), 64'(obs()),
                64'(want(m_q.size() > 0, hd[23:8], hd[7:0],
                         m_pc,
                         m_mode == 2 && m_q.size() == 0)));
        end

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
